// File: rtl/sanojn_ttrpg_dice_pkg.sv
// Shared constants, I2C state encoding and small helper functions for the
// TinyTapeout dice roller.
package sanojn_ttrpg_dice_pkg;

    localparam logic [3:0] BLANK_CODE = 4'hF;
    localparam logic [7:0] DIGIT_REG  = 8'h0A;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic [2:0] {
        IDLE, ADDR, ACK_ADDR, SUB, ACK_SUB, DATA, ACK_DATA, IGNORE
    } i2c_state_e;

    function automatic logic [6:0] die_size(input logic [2:0] idx);
        case (idx)
            3'd0:    return 7'd4;
            3'd1:    return 7'd6;
            3'd2:    return 7'd8;
            3'd3:    return 7'd10;
            3'd4:    return 7'd12;
            3'd5:    return 7'd20;
            3'd6:    return 7'd100;
            default: return 7'd4;
        endcase
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] code);
        case (code)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

    // Returns {tens, ones}; 100 wraps to "00", single digits blank the tens.
    function automatic logic [7:0] bin2bcd(input logic [6:0] v);
        logic [3:0] tens;
        logic [3:0] ones;
        if (v >= 7'd100) begin
            tens = 4'd0;
            ones = 4'd0;
        end else if (v < 7'd10) begin
            tens = BLANK_CODE;
            ones = v[3:0];
        end else begin
            tens = 4'(v / 7'd10);
            ones = 4'(v % 7'd10);
        end
        return {tens, ones};
    endfunction

endpackage

// File: rtl/sanojn_ttrpg_dice_if.sv
// I2C pin bundle: synchronizer-side SCL/SDA inputs and the open-drain SDA enable.
interface sanojn_ttrpg_dice_if;
    logic scl;
    logic sda;
    logic sda_oe;

    modport master (output scl, output sda, input sda_oe);
    modport slave  (input scl, input sda, output sda_oe);
endinterface

// File: rtl/sanojn_i2c_slave.sv
// Write-only I2C slave: address match, sub-address pointer, auto-incrementing
// register writes presented as a one-clock strobe.
module sanojn_i2c_slave
    import sanojn_ttrpg_dice_pkg::*;
#(
    parameter logic [6:0] I2C_ADDR = 7'h70
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sanojn_ttrpg_dice_if.slave    bus,
    output logic                  wr_stb_o,
    output logic [7:0]            wr_addr_o,
    output logic [7:0]            wr_data_o
);
    localparam logic [7:0] MATCH = {I2C_ADDR, 1'b0};

    logic [1:0] scl_sync_q, sda_sync_q;
    logic       scl_prev_q, sda_prev_q;
    logic       scl_s, sda_s, start_s, stop_s, scl_rise_s, scl_fall_s;
    i2c_state_e state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d, ptr_q, ptr_d, wr_addr_q, wr_addr_d, wr_data_q, wr_data_d;
    logic       sda_oe_q, sda_oe_d, wr_stb_q, wr_stb_d;

    assign scl_s      = scl_sync_q[1];
    assign sda_s      = sda_sync_q[1];
    assign start_s    = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_s     = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
    assign scl_rise_s = scl_s & ~scl_prev_q;
    assign scl_fall_s = ~scl_s & scl_prev_q;

    // Bus protocol next-state; START/STOP override every state.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        ptr_d     = ptr_q;
        sda_oe_d  = sda_oe_q;
        wr_stb_d  = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (start_s) begin
            state_d   = ADDR;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
        end else if (stop_s) begin
            state_d  = IDLE;
            sda_oe_d = 1'b0;
        end else begin
            case (state_q)
                ADDR, SUB, DATA: begin
                    if (scl_rise_s) begin
                        shift_d   = {shift_q[6:0], sda_s};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall_s && (bit_cnt_q == 4'd8)) begin
                        bit_cnt_d = 4'd0;
                        case (state_q)
                            ADDR: begin
                                if (shift_q == MATCH) begin
                                    state_d  = ACK_ADDR;
                                    sda_oe_d = 1'b1;
                                end else begin
                                    state_d  = IGNORE;
                                end
                            end
                            SUB: begin
                                state_d  = ACK_SUB;
                                sda_oe_d = 1'b1;
                                ptr_d    = shift_q;
                            end
                            default: begin
                                state_d   = ACK_DATA;
                                sda_oe_d  = 1'b1;
                                wr_stb_d  = 1'b1;
                                wr_addr_d = ptr_q;
                                wr_data_d = shift_q;
                                ptr_d     = ptr_q + 8'd1;
                            end
                        endcase
                    end else begin
                        bit_cnt_d = bit_cnt_q;
                    end
                end
                ACK_ADDR, ACK_SUB, ACK_DATA: begin
                    if (scl_fall_s) begin
                        sda_oe_d = 1'b0;
                        state_d  = (state_q == ACK_ADDR) ? SUB : DATA;
                    end else begin
                        sda_oe_d = 1'b1;
                    end
                end
                IDLE, IGNORE: state_d = state_q;
                default:      state_d = IDLE;
            endcase
        end
    end

    // Pin synchronizers and protocol registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
            state_q    <= IDLE;
            bit_cnt_q  <= 4'd0;
            shift_q    <= 8'd0;
            ptr_q      <= 8'd0;
            sda_oe_q   <= 1'b0;
            wr_stb_q   <= 1'b0;
            wr_addr_q  <= 8'd0;
            wr_data_q  <= 8'd0;
        end else begin
            scl_sync_q <= {scl_sync_q[0], bus.scl};
            sda_sync_q <= {sda_sync_q[0], bus.sda};
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            ptr_q      <= ptr_d;
            sda_oe_q   <= sda_oe_d;
            wr_stb_q   <= wr_stb_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    assign bus.sda_oe = sda_oe_q;
    assign wr_stb_o   = wr_stb_q;
    assign wr_addr_o  = wr_addr_q;
    assign wr_data_o  = wr_data_q;

endmodule

// File: rtl/sanojn_ttrpg_dice.sv
// Dice roller top: button sync, roll counter, BCD digits, multiplexed
// 7-segment drive, and the I2C digit override.
module sanojn_ttrpg_dice
    import sanojn_ttrpg_dice_pkg::*;
#(
    parameter int unsigned MUX_BITS = 10,
    parameter logic [6:0]  I2C_ADDR = 7'h70
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    logic [6:0]        btn_meta_q, btn_sync_q, pressed_s;
    logic              any_s, held_q, sel_s;
    logic [2:0]        die_s, die_q, die_d;
    logic [6:0]        cnt_q, cnt_d;
    logic [3:0]        digit10_q, digit1_q, code_s;
    logic [7:0]        digits_d, seg_s, uo_out_q, uo_out_d;
    logic [1:0]        com_q, com_d;
    logic [MUX_BITS:0] mux_q;
    logic              wr_stb_s;
    logic [7:0]        wr_addr_s, wr_data_s;
    logic              unused_s;

    sanojn_ttrpg_dice_if i2c_bus ();
    assign i2c_bus.scl = uio_in[3];
    assign i2c_bus.sda = uio_in[2];

    sanojn_i2c_slave #(.I2C_ADDR(I2C_ADDR)) u_i2c (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (i2c_bus),
        .wr_stb_o  (wr_stb_s),
        .wr_addr_o (wr_addr_s),
        .wr_data_o (wr_data_s)
    );

    assign pressed_s = btn_sync_q ^ {7{~uio_in[5]}};
    assign any_s     = |pressed_s;
    assign unused_s  = &{1'b0, ena, ui_in[7], uio_in[4], uio_in[1:0]};

    // Lowest-index pressed button selects the die.
    always_comb begin
        casez (pressed_s)
            7'b??????1: die_s = 3'd0;
            7'b?????10: die_s = 3'd1;
            7'b????100: die_s = 3'd2;
            7'b???1000: die_s = 3'd3;
            7'b??10000: die_s = 3'd4;
            7'b?100000: die_s = 3'd5;
            7'b1000000: die_s = 3'd6;
            default:    die_s = 3'd0;
        endcase
    end

    // Roll counter restarts at 1 on a fresh press or die change, else wraps N->1.
    always_comb begin
        die_d = die_q;
        cnt_d = cnt_q;
        if (any_s) begin
            die_d = die_s;
            if (!held_q || (die_s != die_q) || (cnt_q >= die_size(die_s))) begin
                cnt_d = 7'd1;
            end else begin
                cnt_d = cnt_q + 7'd1;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Digits track the live counter while held; otherwise an I2C write may load them.
    always_comb begin
        if (held_q) begin
            digits_d = bin2bcd(cnt_q);
        end else if (wr_stb_s && (wr_addr_s == DIGIT_REG)) begin
            digits_d = wr_data_s;
        end else begin
            digits_d = {digit10_q, digit1_q};
        end
    end

    // Digit multiplex with configurable segment and common polarity.
    always_comb begin
        sel_s    = mux_q[MUX_BITS];
        code_s   = sel_s ? digit10_q : digit1_q;
        seg_s    = {1'b0, seg7(code_s)};
        uo_out_d = uio_in[6] ? seg_s : ~seg_s;
        com_d    = sel_s ? {uio_in[7], ~uio_in[7]} : {~uio_in[7], uio_in[7]};
    end

    // State and registered display outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_meta_q <= 7'd0;
            btn_sync_q <= 7'd0;
            held_q     <= 1'b0;
            die_q      <= 3'd0;
            cnt_q      <= 7'd0;
            digit10_q  <= BLANK_CODE;
            digit1_q   <= BLANK_CODE;
            mux_q      <= {(MUX_BITS + 1){1'b0}};
            uo_out_q   <= 8'h00;
            com_q      <= 2'b00;
        end else begin
            btn_meta_q <= ui_in[6:0];
            btn_sync_q <= btn_meta_q;
            held_q     <= any_s;
            die_q      <= die_d;
            cnt_q      <= cnt_d;
            digit10_q  <= digits_d[7:4];
            digit1_q   <= digits_d[3:0];
            mux_q      <= mux_q + (MUX_BITS + 1)'(1);
            uo_out_q   <= uo_out_d;
            com_q      <= com_d;
        end
    end

    assign uo_out  = uo_out_q;
    assign uio_out = {6'b000000, com_q};
    assign uio_oe  = {5'b00000, i2c_bus.sda_oe, 2'b11};

endmodule

// File: tb/tb_sanojn_ttrpg_dice.sv
// Directed bench for the dice roller: rolls, polarity sweep, I2C digit writes, resets.
module tb_sanojn_ttrpg_dice;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uo_out, uio_in, uio_out, uio_oe;
    logic       pol_btn = 1'b1, pol_seg = 1'b1, pol_com = 1'b1;
    logic       sda_line, ack;
    logic [7:0] ones, tens;
    int         tests_run = 0, tests_failed = 0;

    sanojn_ttrpg_dice_if tb_bus ();

    assign tb_bus.sda_oe = uio_oe[2];
    assign sda_line      = tb_bus.sda & ~tb_bus.sda_oe;
    assign uio_in        = {pol_com, pol_seg, pol_btn, 1'b0, tb_bus.scl, sda_line, 2'b00};

    sanojn_ttrpg_dice #(.MUX_BITS(3), .I2C_ADDR(7'h70)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] idle_btn();
        return pol_btn ? 8'h00 : 8'hFF;
    endfunction

    function automatic logic [7:0] btn(input logic [7:0] mask);
        return pol_btn ? mask : ~mask;
    endfunction

    task automatic roll(input logic [7:0] mask, input int hold);
        @(negedge clk);
        ui_in = btn(mask);
        repeat (hold) @(negedge clk);
        ui_in = idle_btn();
        repeat (6) @(negedge clk);
    endtask

    task automatic read_disp(output logic [7:0] o, output logic [7:0] t);
        int n;
        n = 0;
        while (!(uio_out[0] == pol_com && uio_out[1] == ~pol_com) && n < 64) begin
            @(negedge clk);
            n++;
        end
        check("mux_ones_wait", 32'(n < 64), 32'd1);
        o = pol_seg ? uo_out : ~uo_out;
        n = 0;
        while (!(uio_out[1] == pol_com && uio_out[0] == ~pol_com) && n < 64) begin
            @(negedge clk);
            n++;
        end
        check("mux_tens_wait", 32'(n < 64), 32'd1);
        t = pol_seg ? uo_out : ~uo_out;
    endtask

    task automatic qwait();
        repeat (8) @(negedge clk);
    endtask

    task automatic i2c_start();
        tb_bus.sda = 1'b1; qwait();
        tb_bus.scl = 1'b1; qwait();
        tb_bus.sda = 1'b0; qwait();
        tb_bus.scl = 1'b0; qwait();
    endtask

    task automatic i2c_stop();
        tb_bus.sda = 1'b0; qwait();
        tb_bus.scl = 1'b1; qwait();
        tb_bus.sda = 1'b1; qwait();
    endtask

    task automatic send_bit(input logic b);
        tb_bus.sda = b; qwait();
        tb_bus.scl = 1'b1; qwait(); qwait();
        tb_bus.scl = 1'b0;
    endtask

    task automatic i2c_byte(input logic [7:0] b, output logic a);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        qwait();
        tb_bus.sda = 1'b1; qwait();
        tb_bus.scl = 1'b1; qwait();
        a = ~sda_line;
        qwait();
        tb_bus.scl = 1'b0; qwait();
    endtask

    initial begin
        tb_bus.scl = 1'b1;
        tb_bus.sda = 1'b1;
        // reset state, cfg = 111
        repeat (5) @(negedge clk);
        check("rst_digit1", 32'(dut.digit1_q), 32'd15);
        check("rst_digit10", 32'(dut.digit10_q), 32'd15);
        check("rst_uio_oe", 32'(uio_oe), 32'h03);
        check("rst_uo_out", 32'(uo_out), 32'h00);
        check("rst_sda_out", 32'(uio_out[2]), 32'd0);
        rst_n = 1'b1;
        read_disp(ones, tens);
        check("rst_disp_ones", 32'(ones), 32'h00);
        check("rst_disp_tens", 32'(tens), 32'h00);

        // d6 held 1000 clocks: 1000 counter steps starting at 1 -> (999 mod 6)+1 = 4
        roll(8'h02, 1000);
        check("d6_digit1", 32'(dut.digit1_q), 32'd4);
        check("d6_digit10", 32'(dut.digit10_q), 32'd15);
        read_disp(ones, tens);
        check("d6_seg_ones", 32'(ones), 32'h66);
        check("d6_seg_tens", 32'(tens), 32'h00);

        // d100 held 100 clocks -> counter at 100 -> "00"
        roll(8'h40, 100);
        check("d100_digit10", 32'(dut.digit10_q), 32'd0);
        check("d100_digit1", 32'(dut.digit1_q), 32'd0);
        read_disp(ones, tens);
        check("d100_seg_ones", 32'(ones), 32'h3F);
        check("d100_seg_tens", 32'(tens), 32'h3F);

        // d10 held 10 clocks -> 10
        roll(8'h08, 10);
        read_disp(ones, tens);
        check("d10_seg_ones", 32'(ones), 32'h3F);
        check("d10_seg_tens", 32'(tens), 32'h06);

        // d20 for 7 clocks, then d12 joins (wins) for 15: restart -> (14 mod 12)+1 = 3
        @(negedge clk);
        ui_in = 8'h20;
        repeat (7) @(negedge clk);
        ui_in = 8'h30;
        repeat (15) @(negedge clk);
        ui_in = 8'h00;
        repeat (6) @(negedge clk);
        check("switch_digit1", 32'(dut.digit1_q), 32'd3);
        check("switch_digit10", 32'(dut.digit10_q), 32'd15);

        // polarity sweep: d8 held 13 clocks -> (12 mod 8)+1 = 5 in both configs
        roll(8'h04, 13);
        read_disp(ones, tens);
        check("pol111_ones", 32'(ones), 32'h6D);
        check("pol111_tens", 32'(tens), 32'h00);
        @(negedge clk);
        pol_btn = 1'b0; pol_seg = 1'b0; pol_com = 1'b0;
        ui_in = 8'hFF;
        repeat (10) @(negedge clk);
        roll(8'h04, 13);
        read_disp(ones, tens);
        check("pol000_ones", 32'(ones), 32'h6D);
        check("pol000_tens", 32'(tens), 32'h00);
        check("pol000_com", 32'(uio_out[1:0]), 32'h1);
        check("pol000_raw", 32'(uo_out), 32'hFF);
        @(negedge clk);
        pol_btn = 1'b1; pol_seg = 1'b1; pol_com = 1'b1;
        ui_in = 8'h00;
        repeat (10) @(negedge clk);

        // I2C write 0x55 to 0x0A and 0x1F to 0x0B
        i2c_start();
        i2c_byte(8'hE0, ack); check("ack_addr", 32'(ack), 32'd1);
        i2c_byte(8'h0A, ack); check("ack_sub", 32'(ack), 32'd1);
        i2c_byte(8'h55, ack); check("ack_data0", 32'(ack), 32'd1);
        i2c_byte(8'h1F, ack); check("ack_data1", 32'(ack), 32'd1);
        i2c_stop();
        repeat (4) @(negedge clk);
        check("i2c_digit10", 32'(dut.digit10_q), 32'd5);
        check("i2c_digit1", 32'(dut.digit1_q), 32'd5);
        read_disp(ones, tens);
        check("i2c_seg_ones", 32'(ones), 32'h6D);
        check("i2c_seg_tens", 32'(tens), 32'h6D);

        // read request 0x71: no ACK, nothing written
        i2c_start();
        i2c_byte(8'hE3, ack); check("nack_read", 32'(ack), 32'd0);
        i2c_byte(8'h0A, ack); check("nack_read_sub", 32'(ack), 32'd0);
        i2c_byte(8'h12, ack); check("nack_read_data", 32'(ack), 32'd0);
        i2c_stop();
        repeat (4) @(negedge clk);
        check("nack_read_digits", 32'({dut.digit10_q, dut.digit1_q}), 32'h55);

        // foreign address 0x22, then repeated START to 0x70 writes 0x37
        i2c_start();
        i2c_byte(8'h44, ack); check("nack_foreign", 32'(ack), 32'd0);
        i2c_start();
        i2c_byte(8'hE0, ack); check("rstart_addr", 32'(ack), 32'd1);
        i2c_byte(8'h0A, ack); check("rstart_sub", 32'(ack), 32'd1);
        i2c_byte(8'h37, ack); check("rstart_data", 32'(ack), 32'd1);
        i2c_stop();
        repeat (4) @(negedge clk);
        read_disp(ones, tens);
        check("rstart_seg_ones", 32'(ones), 32'h07);
        check("rstart_seg_tens", 32'(tens), 32'h4F);

        // reset in the middle of a data byte: no partial write survives
        i2c_start();
        i2c_byte(8'hE0, ack);
        i2c_byte(8'h0A, ack);
        for (int i = 7; i >= 4; i--) send_bit(1'b1);
        rst_n = 1'b0;
        #1;
        check("midi2c_digits", 32'({dut.digit10_q, dut.digit1_q}), 32'hFF);
        check("midi2c_uio_oe", 32'(uio_oe), 32'h03);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 3; i >= 0; i--) send_bit(1'b1);
        qwait();
        i2c_stop();
        repeat (4) @(negedge clk);
        check("midi2c_after", 32'({dut.digit10_q, dut.digit1_q}), 32'hFF);

        // reset while a die is held
        @(negedge clk);
        ui_in = 8'h20;
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midroll_cnt", 32'(dut.cnt_q), 32'd0);
        check("midroll_digits", 32'({dut.digit10_q, dut.digit1_q}), 32'hFF);
        @(negedge clk);
        ui_in = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
